// File: rtl/cpu7_exu_ecldstpipe.sv
// ---------------------------------------------------------------------------
// cpu7_exu_ecldstpipe
//
// Tracks the destination register and write enable of each EXU instruction
// from E through M to W. The M/W bypass-select logic uses these values.
// Also owns the load-use interlock:
//   - it freezes M while a load there waits for LSU data (hold_m);
//   - it holds E while an E consumer needs that load (stall_e).
//
// Optional build macro: CPU7_LDDATA_BYPASS_M_EN
//   Defined   : load data is forwarded from M on its return cycle, so no
//               bubble is inserted once the data is back.
//   Undefined : a consumer directly behind a load always sees one bubble.
//
// Ports
//   clk, resetn                 clock; asynchronous active-low reset
//   vld_e, rd_e, wen_e, load_e  E instruction: valid, destination,
//                               write enable, is-load
//   rs1_e/rs2_e, rsN_use_e      E source registers and their read qualifiers
//   flush_e                     drop the E instruction
//   kill_m                      kill the M instruction; it reaches W with
//                               its write suppressed
//   lsu_data_vld_m              data for the M load returns this cycle
//   rd_m, rd_w                  M/W destination registers
//   wen_m, wen_w                qualified M/W write enables
//   load_m                      a valid load is in M
//   stall_e                     hold E and everything upstream
//   hold_m                      M is frozen waiting for load data
// ---------------------------------------------------------------------------
module cpu7_exu_ecldstpipe (
  input  logic       clk,
  input  logic       resetn,
  input  logic       vld_e,
  input  logic [4:0] rd_e,
  input  logic       wen_e,
  input  logic       load_e,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic       rs1_use_e,
  input  logic       rs2_use_e,
  input  logic       flush_e,
  input  logic       kill_m,
  input  logic       lsu_data_vld_m,
  output logic [4:0] rd_m,
  output logic [4:0] rd_w,
  output logic       wen_m,
  output logic       wen_w,
  output logic       load_m,
  output logic       stall_e,
  output logic       hold_m
);

  typedef enum logic {
    RUN    = 1'b0,
    LDWAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic vld_m;
  logic wen_m_r;
  logic load_m_r;
  logic rs1_hit, rs2_hit, lduse, take_e;

  // A kill always wins: a killed load must not hold the pipe.
  assign hold_m = vld_m & load_m_r & ~lsu_data_vld_m & ~kill_m;

  // Register x0 never creates a dependency.
  assign rs1_hit = rs1_use_e & (rs1_e != 5'd0) & (rs1_e == rd_m);
  assign rs2_hit = rs2_use_e & (rs2_e != 5'd0) & (rs2_e == rd_m);

`ifdef CPU7_LDDATA_BYPASS_M_EN
  // Returned data is forwarded from M, so only an outstanding load stalls.
  assign lduse = vld_e & vld_m & load_m_r & wen_m_r & ~lsu_data_vld_m
               & (rs1_hit | rs2_hit);
`else
  assign lduse = vld_e & vld_m & load_m_r & wen_m_r & (rs1_hit | rs2_hit);
`endif

  assign stall_e = hold_m | lduse;
  // flush_e only drops E; stall_e above is not affected by it.
  assign take_e  = vld_e & ~flush_e & ~stall_e;

  assign wen_m  = vld_m & wen_m_r & ~kill_m;
  assign load_m = vld_m & load_m_r;

  // FSM: the state records that an M load is outstanding.
  always_comb begin
    // NOTE: next state gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      RUN:     if (vld_m & load_m_r & ~lsu_data_vld_m & ~kill_m) state_d = LDWAIT;
      LDWAIT:  if (lsu_data_vld_m | kill_m)                      state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
    end
  end

  // M and W register sets.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_m    <= 1'b0;
      rd_m     <= 5'd0;
      wen_m_r  <= 1'b0;
      load_m_r <= 1'b0;
      rd_w     <= 5'd0;
      wen_w    <= 1'b0;
    end else if (hold_m) begin
      // M is frozen, so a bubble goes to W. rd_w keeps its value.
      wen_w <= 1'b0;
    end else begin
      wen_w <= wen_m;
      rd_w  <= rd_m;
      if (take_e) begin
        vld_m    <= 1'b1;
        rd_m     <= rd_e;
        wen_m_r  <= wen_e;
        load_m_r <= load_e;
      end else begin
        // Bubble into M. rd_m keeps its value.
        vld_m    <= 1'b0;
        wen_m_r  <= 1'b0;
        load_m_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu7_exu_ecldstpipe.sv
module tb_cpu7_exu_ecldstpipe;

  logic       clk = 1'b0;
  logic       resetn;
  logic       vld_e, wen_e, load_e, rs1_use_e, rs2_use_e;
  logic [4:0] rd_e, rs1_e, rs2_e;
  logic       flush_e, kill_m, lsu_data_vld_m;
  logic [4:0] rd_m, rd_w;
  logic       wen_m, wen_w, load_m, stall_e, hold_m;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CPU7_LDDATA_BYPASS_M_EN
  localparam logic LDUSE_STALL = 1'b0;
`else
  localparam logic LDUSE_STALL = 1'b1;
`endif

  cpu7_exu_ecldstpipe dut (
    .clk(clk), .resetn(resetn),
    .vld_e(vld_e), .rd_e(rd_e), .wen_e(wen_e), .load_e(load_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_use_e(rs1_use_e), .rs2_use_e(rs2_use_e),
    .flush_e(flush_e), .kill_m(kill_m), .lsu_data_vld_m(lsu_data_vld_m),
    .rd_m(rd_m), .rd_w(rd_w), .wen_m(wen_m), .wen_w(wen_w),
    .load_m(load_m), .stall_e(stall_e), .hold_m(hold_m)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step one clock edge. Inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input logic [4:0] rd, input logic w, input logic ld,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    vld_e = v; rd_e = rd; wen_e = w; load_e = ld;
    rs1_e = s1; rs1_use_e = u1; rs2_e = s2; rs2_use_e = u2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    flush_e = 0; kill_m = 0; lsu_data_vld_m = 0;

    // Reset state
    #2;
    check("rst_rd_m",    32'(rd_m),    32'd0);
    check("rst_rd_w",    32'(rd_w),    32'd0);
    check("rst_wen_m",   32'(wen_m),   32'd0);
    check("rst_wen_w",   32'(wen_w),   32'd0);
    check("rst_load_m",  32'(load_m),  32'd0);
    check("rst_stall_e", 32'(stall_e), 32'd0);
    check("rst_hold_m",  32'(hold_m),  32'd0);
    tick();
    resetn = 1'b1;

    // ALU pipe: rd=5 then rd=6
    set_e(1, 5, 1, 0, 0, 0, 0, 0); settle();
    check("alu_stall0", 32'(stall_e), 32'd0);
    tick();
    set_e(1, 6, 1, 0, 0, 0, 0, 0); settle();
    check("alu_rd_m5",   32'(rd_m),    32'd5);
    check("alu_wen_m5",  32'(wen_m),   32'd1);
    check("alu_load_m",  32'(load_m),  32'd0);
    check("alu_stall1",  32'(stall_e), 32'd0);
    tick();
    set_e(0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("alu_rd_w5",   32'(rd_w),  32'd5);
    check("alu_wen_w5",  32'(wen_w), 32'd1);
    check("alu_rd_m6",   32'(rd_m),  32'd6);
    tick(); settle();
    check("alu_rd_w6",   32'(rd_w),  32'd6);
    check("alu_wen_w6",  32'(wen_w), 32'd1);
    check("alu_bubble",  32'(wen_m), 32'd0);

    // Load wait: rd=7, three cycles with no data, then data returns
    set_e(1, 7, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("ldw_hold1",   32'(hold_m),  32'd1);
    check("ldw_stall1",  32'(stall_e), 32'd1);
    check("ldw_load_m",  32'(load_m),  32'd1);
    check("ldw_wen_w1",  32'(wen_w),   32'd0);
    tick(); settle();
    check("ldw_hold2",   32'(hold_m),  32'd1);
    check("ldw_wen_w2",  32'(wen_w),   32'd0);
    check("ldw_rd_m2",   32'(rd_m),    32'd7);
    tick(); settle();
    check("ldw_hold3",   32'(hold_m),  32'd1);
    check("ldw_stall3",  32'(stall_e), 32'd1);
    check("ldw_wen_w3",  32'(wen_w),   32'd0);
    lsu_data_vld_m = 1; settle();
    check("ldw_hold_rel",  32'(hold_m),  32'd0);
    check("ldw_stall_rel", 32'(stall_e), 32'd0);
    tick();
    lsu_data_vld_m = 0; settle();
    check("ldw_rd_w7",   32'(rd_w),  32'd7);
    check("ldw_wen_w7",  32'(wen_w), 32'd1);
    check("ldw_m_empty", 32'(wen_m), 32'd0);

    // Load-use: load rd=3, data on its first M cycle, consumer rs1=3
    set_e(1, 3, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(1, 8, 1, 0, 3, 1, 0, 0);
    lsu_data_vld_m = 1; settle();
    check("lu_hold",  32'(hold_m),  32'd0);
    check("lu_stall", 32'(stall_e), 32'(LDUSE_STALL));
    tick();
    lsu_data_vld_m = 0; settle();
    check("lu_rd_w3",  32'(rd_w),  32'd3);
    check("lu_wen_w3", 32'(wen_w), 32'd1);
`ifdef CPU7_LDDATA_BYPASS_M_EN
    check("lu_rd_m8",  32'(rd_m),  32'd8);
    check("lu_wen_m8", 32'(wen_m), 32'd1);
`else
    check("lu_bubble_wen_m", 32'(wen_m),   32'd0);
    check("lu_bubble_load",  32'(load_m),  32'd0);
    check("lu_stall_clear",  32'(stall_e), 32'd0);
    tick(); settle();
    check("lu_rd_m8",  32'(rd_m),  32'd8);
    check("lu_wen_m8", 32'(wen_m), 32'd1);
`endif
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // x0 source: load rd=0, E load rd=4 reads rs1=0
    set_e(1, 0, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(1, 4, 1, 1, 0, 1, 0, 0);
    lsu_data_vld_m = 1; settle();
    check("x0_stall",  32'(stall_e), 32'd0);
    check("x0_wen_m",  32'(wen_m),   32'd1);
    check("x0_rd_m",   32'(rd_m),    32'd0);
    tick();
    // Unused source: rs2 matches load rd=4, but rs2_use_e is 0
    set_e(1, 10, 1, 0, 0, 0, 4, 0); settle();
    check("rs2_unused_stall", 32'(stall_e), 32'd0);
    check("x0_wen_w",  32'(wen_w), 32'd1);
    check("x0_rd_w",   32'(rd_w),  32'd0);
    rs2_use_e = 1; settle();
    check("rs2_used_stall", 32'(stall_e), 32'(LDUSE_STALL));
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    lsu_data_vld_m = 0; settle();
    check("ld4_rd_w",  32'(rd_w),  32'd4);
    check("ld4_wen_w", 32'(wen_w), 32'd1);

    // Kill a load while it is in LDWAIT
    set_e(1, 11, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); settle();
    check("kill_hold_pre", 32'(hold_m), 32'd1);
    kill_m = 1; settle();
    check("kill_hold",   32'(hold_m),  32'd0);
    check("kill_stall",  32'(stall_e), 32'd0);
    check("kill_wen_m",  32'(wen_m),   32'd0);
    check("kill_load_m", 32'(load_m),  32'd1);
    tick();
    kill_m = 0; settle();
    check("kill_wen_w",  32'(wen_w), 32'd0);
    check("kill_rd_w",   32'(rd_w),  32'd11);

    // Data return and kill in the same cycle: the kill wins
    set_e(1, 12, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    lsu_data_vld_m = 1; kill_m = 1; settle();
    check("lk_hold",  32'(hold_m), 32'd0);
    tick();
    lsu_data_vld_m = 0; kill_m = 0; settle();
    check("lk_wen_w", 32'(wen_w), 32'd0);

    // Flush E while not stalled: M gets a bubble
    set_e(1, 13, 1, 0, 0, 0, 0, 0);
    flush_e = 1; settle();
    check("flush_stall", 32'(stall_e), 32'd0);
    tick();
    flush_e = 0;
    set_e(0, 0, 0, 0, 0, 0, 0, 0); settle();
    check("flush_wen_m", 32'(wen_m), 32'd0);

    // Reset while a load is in LDWAIT
    set_e(1, 14, 1, 1, 0, 0, 0, 0);
    tick();
    set_e(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); settle();
    check("rl_hold_pre", 32'(hold_m), 32'd1);
    resetn = 0; settle();
    check("rl_hold",   32'(hold_m),  32'd0);
    check("rl_stall",  32'(stall_e), 32'd0);
    check("rl_rd_m",   32'(rd_m),    32'd0);
    check("rl_rd_w",   32'(rd_w),    32'd0);
    check("rl_wen_m",  32'(wen_m),   32'd0);
    check("rl_wen_w",  32'(wen_w),   32'd0);
    check("rl_load_m", 32'(load_m),  32'd0);
    tick();
    resetn = 1;
    tick(); settle();
    check("rl_post_wen_w", 32'(wen_w),  32'd0);
    check("rl_post_hold",  32'(hold_m), 32'd0);
    tick(); settle();
    check("rl_post_wen_w2", 32'(wen_w), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
